// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic phase controller: mode decode
// of the select switch and a one-hot lamp helper.
package traffic_pkg;

  localparam int unsigned SEL_W = 8;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_SET  = 2'd1,
    MODE_IDLE = 2'd2
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [SEL_W-1:0] idx;
  } mode_dec_t;

  // sel 0 runs, 1..nph edits phase sel-1, anything above is idle
  function automatic mode_dec_t decode_mode(input logic [SEL_W-1:0] sel,
                                            input int unsigned      nph);
    mode_dec_t r;
    r.mode = MODE_IDLE;
    r.idx  = '0;
    if (sel == '0) begin
      r.mode = MODE_RUN;
    end else if (32'(sel) <= nph) begin
      r.mode = MODE_SET;
      r.idx  = sel - SEL_W'(1);
    end
    return r;
  endfunction

  function automatic logic [31:0] onehot(input logic [SEL_W-1:0] idx);
    return 32'(1) << idx;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Remaining-count register for the active phase: loads a duration or
// counts down, flagging the final cycle of the phase.
module phase_timer #(
  parameter int unsigned W       = 4,
  parameter int unsigned RST_VAL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] remain,
  output logic         last
);

  logic [W-1:0] remain_q;
  logic [W-1:0] remain_d;

  always_comb begin
    remain_d = remain_q;
    if (load) begin
      remain_d = load_val;
    end else if (en) begin
      remain_d = remain_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain_q <= W'(RST_VAL);
    end else begin
      remain_q <= remain_d;
    end
  end

  assign remain = remain_q;
  assign last   = (remain_q == W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase sequencer with per-phase editable durations; RUN
// counts phases down, SET shows/edits one duration, IDLE blanks and freezes.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned LED_W   = 4,
  parameter int unsigned NPH     = 3,
  parameter int unsigned DEF_DUR = 4,
  parameter int unsigned SW_W    = $clog2(NPH + 1),
  parameter int unsigned PH_W    = (NPH > 1) ? $clog2(NPH) : 1
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw,
  input  logic             inc,
  output logic [LED_W-1:0] led,
  output logic [NPH-1:0]   lamp,
  output logic [PH_W-1:0]  phase
);

  mode_dec_t        dec;
  logic             is_run;
  logic             is_set;
  logic [PH_W-1:0]  set_ph;

  logic [LED_W-1:0] dur_q [NPH];
  logic [LED_W-1:0] dur_d [NPH];
  logic [PH_W-1:0]  ph_q;
  logic [PH_W-1:0]  ph_d;
  logic             prev_run_q;
  logic             prev_run_d;

  logic [PH_W-1:0]  next_ph;
  logic             tmr_load;
  logic [LED_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic [LED_W-1:0] remain;
  logic             last;

  assign dec    = decode_mode(SEL_W'(sw), NPH);
  assign is_run = (dec.mode == MODE_RUN);
  assign is_set = (dec.mode == MODE_SET);
  assign set_ph = PH_W'(dec.idx);

  assign next_ph = (ph_q == PH_W'(NPH - 1)) ? '0 : ph_q + PH_W'(1);

  // Duration edit: wraps from all-ones back to 1 so a phase never has zero length
  always_comb begin
    dur_d = dur_q;
    if (is_set && inc) begin
      if (dur_q[set_ph] == '1) begin
        dur_d[set_ph] = LED_W'(1);
      end else begin
        dur_d[set_ph] = dur_q[set_ph] + LED_W'(1);
      end
    end
  end

  // Re-entry into RUN restarts from phase 0 with freshly loaded duration
  always_comb begin
    ph_d         = ph_q;
    prev_run_d   = is_run;
    tmr_load     = 1'b0;
    tmr_load_val = dur_q[0];
    tmr_en       = 1'b0;
    if (is_run) begin
      if (!prev_run_q) begin
        ph_d     = '0;
        tmr_load = 1'b1;
      end else if (last) begin
        ph_d         = next_ph;
        tmr_load     = 1'b1;
        tmr_load_val = dur_q[next_ph];
      end else begin
        tmr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NPH); i++) begin
        dur_q[i] <= LED_W'(DEF_DUR);
      end
      ph_q       <= '0;
      prev_run_q <= 1'b1;
    end else begin
      dur_q      <= dur_d;
      ph_q       <= ph_d;
      prev_run_q <= prev_run_d;
    end
  end

  phase_timer #(
    .W       (LED_W),
    .RST_VAL (DEF_DUR)
  ) u_timer (
    .clk      (clk_div),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .remain   (remain),
    .last     (last)
  );

  always_comb begin
    led  = '0;
    lamp = '0;
    if (is_run) begin
      led  = remain;
      lamp = NPH'(onehot(SEL_W'(ph_q)));
    end else if (is_set) begin
      led  = dur_q[set_ph];
      lamp = NPH'(onehot(dec.idx));
    end
  end

  assign phase = ph_q;

endmodule
